// File: rtl/div_seq_unit_pkg.sv
// rtl/div_seq_unit_pkg.sv - shared handshake state encoding and size defaults for the DIV unit
package div_seq_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    // The control unit's DIV wait states decode these same values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_unit_if.sv
// rtl/div_seq_unit_if.sv - DIV request/response bundle between control unit and divider
interface div_seq_unit_if
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  div_zero,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output div_zero,
        output hi,
        output lo
    );

endinterface

// File: rtl/abs_neg_32.sv
// rtl/abs_neg_32.sv - conditional two's-complement negate for magnitudes and result sign fix
module abs_neg_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = neg ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - multicycle signed restoring divider: quotient to LO, remainder to HI
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    div_seq_unit_if.slave bus
);

    div_state_t       state;
    div_state_t       next_state;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             dz_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             b_zero;
    logic             accept;

    abs_neg_32 #(.WIDTH(WIDTH)) u_abs_a (
        .value  (bus.dividend),
        .neg    (bus.dividend[WIDTH-1]),
        .result (abs_a)
    );

    abs_neg_32 #(.WIDTH(WIDTH)) u_abs_b (
        .value  (bus.divisor),
        .neg    (bus.divisor[WIDTH-1]),
        .result (abs_b)
    );

    abs_neg_32 #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (quo),
        .neg    (sign_q),
        .result (fix_quo)
    );

    abs_neg_32 #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (rem),
        .neg    (sign_r),
        .result (fix_rem)
    );

    // The extra top bit makes the trial subtraction's sign the restore decision.
    always_comb begin
        b_zero = (bus.divisor == '0);
        accept = (state == IDLE) && bus.start;
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            if (accept) begin
                dz_q <= b_zero;
                if (!b_zero) begin
                    quo    <= abs_a;
                    dvs    <= abs_b;
                    rem    <= '0;
                    sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    sign_r <= bus.dividend[WIDTH-1];
                    cnt    <= CNT_W'(WIDTH);
                end
            end

            if (state == RUN) begin
                quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt <= cnt - CNT_W'(1);
            end

            if (state == FIX) begin
                lo_q <= fix_quo;
                hi_q <= fix_rem;
            end
        end
    end

    always_comb begin
        bus.busy     = (state == RUN) || (state == FIX);
        bus.done     = (state == DONE);
        bus.div_zero = dz_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// tb/tb_div_seq_unit.sv - scoreboard bench for the sequential signed divider
module tb_div_seq_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    div_seq_unit_if #(.WIDTH(32)) bus ();

    div_seq_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          start_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 want no done at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
                chk({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                chk({mon_e.name, "_dz"}, 32'(bus.div_zero), 32'(mon_e.dz));
                chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.lo        = elo;
        e.hi        = ehi;
        e.dz        = edz;
        e.start_cyc = cyc + 1;
        e.lat       = edz ? 0 : 33;
        e.name      = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk({nm, "_busy"}, 32'(bus.busy), edz ? 32'd0 : 32'd1);
        chk({nm, "_dz_accept"}, 32'(bus.div_zero), 32'(edz));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_dz"}, 32'(bus.div_zero), 32'd0);
        chk({nm, "_hi"}, bus.hi, 32'd0);
        chk({nm, "_lo"}, bus.lo, 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;

        issue("d100_7", 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
        wait_done("d100_7");
        issue("dm7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        wait_done("dm7_2");
        issue("d7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
        wait_done("d7_m2");
        issue("dm7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0);
        wait_done("dm7_m2");
        issue("dovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        wait_done("dovf");
        issue("d0_5", 32'd0, 32'd5, 32'h0, 32'h0, 1'b0);
        wait_done("d0_5");

        issue("d100_7b", 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
        wait_done("d100_7b");
        issue("d5_0", 32'd5, 32'd0, 32'h0000000E, 32'h00000002, 1'b1);
        wait_done("d5_0");
        issue("d9_3", 32'd9, 32'd3, 32'h00000003, 32'h00000000, 1'b0);
        wait_done("d9_3");

        issue("ign", 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done("ign");

        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.start    = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_zero_outputs("abort");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        issue("d20_6", 32'd20, 32'd6, 32'h00000003, 32'h00000002, 1'b0);
        wait_done("d20_6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
